// File: rtl/wb_dmem_slave_if.sv
// Wishbone data-memory bus: access-width type plus the master/slave interface
// shared by the processor data port and the memory responder.
package wishbone_pkg;
    typedef enum logic [1:0] {
        eDW_B = 2'd0,
        eDW_H = 2'd1,
        eDW_W = 2'd2
    } data_width_e;
endpackage

interface WISHBONE_IF;
    import wishbone_pkg::*;

    logic [31:0] addr;
    logic        we;
    logic        stb;
    logic        cyc;
    data_width_e width;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        ack;

    modport master (
        output addr, we, stb, cyc, width, data_write,
        input  data_read, ack
    );

    modport slave (
        input  addr, we, stb, cyc, width, data_write,
        output data_read, ack
    );
endinterface

// File: rtl/wb_dmem_slave.sv
// On-chip data SRAM behind a Wishbone responder with a configurable number of
// wait states, byte/half/word write lane steering and zero-extended reads.
module wb_dmem_slave
    import wishbone_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = ""
) (
    input logic        clk,
    input logic        rst,
    WISHBONE_IF.slave  mem_wb
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_read_q, data_read_d;

    logic          req;
    logic          commit;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic [31:0]   rshift;
    logic [15:0]   rhalf;
    logic [31:0]   rdata_fmt;
    logic          unused_addr_bits;

    assign req              = mem_wb.stb & mem_wb.cyc;
    assign idx              = mem_wb.addr[AW+1:2];
    assign rword            = mem[idx];
    assign rshift           = rword >> {mem_wb.addr[1:0], 3'b000};
    assign rhalf            = mem_wb.addr[1] ? rword[31:16] : rword[15:0];
    assign unused_addr_bits = ^mem_wb.addr[31:AW+2];

    // Replicate write data across all lanes so the byte enables alone pick the target bytes.
    always_comb begin
        be        = 4'b1111;
        wdata     = mem_wb.data_write;
        rdata_fmt = rword;
        case (mem_wb.width)
            eDW_B: begin
                be        = 4'b0001 << mem_wb.addr[1:0];
                wdata     = {4{mem_wb.data_write[7:0]}};
                rdata_fmt = {24'h0, rshift[7:0]};
            end
            eDW_H: begin
                be        = mem_wb.addr[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{mem_wb.data_write[15:0]}};
                rdata_fmt = {16'h0, rhalf};
            end
            default: begin
                be        = 4'b1111;
                wdata     = mem_wb.data_write;
                rdata_fmt = rword;
            end
        endcase
    end

    // The access commits on the edge that enters ACK; a dropped request in WAIT aborts silently.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d = S_ACK;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        data_read_d = commit ? rdata_fmt : data_read_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            data_read_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_read_q <= data_read_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && mem_wb.we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign mem_wb.ack       = (state_q == S_ACK);
    assign mem_wb.data_read = data_read_q;

endmodule

// File: tb/tb_wb_dmem_slave.sv
// Directed bench for wb_dmem_slave: three instances at LATENCY 1, 3 and 4
// exercising lane steering, wait states, aborts, mid-wait reset and aliasing.
module tb_wb_dmem_slave;
    import wishbone_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    WISHBONE_IF bus1 ();
    WISHBONE_IF bus3 ();
    WISHBONE_IF bus4 ();

    wb_dmem_slave #(.DEPTH_WORDS(1024), .LATENCY(1), .INIT_FILE("")) dut1 (
        .clk(clk), .rst(rst), .mem_wb(bus1)
    );
    wb_dmem_slave #(.DEPTH_WORDS(1024), .LATENCY(3), .INIT_FILE("")) dut3 (
        .clk(clk), .rst(rst), .mem_wb(bus3)
    );
    wb_dmem_slave #(.DEPTH_WORDS(1024), .LATENCY(4), .INIT_FILE("")) dut4 (
        .clk(clk), .rst(rst), .mem_wb(bus4)
    );

    task automatic drive(input int sel, input logic s, input logic c, input logic we,
                         input data_width_e w, input logic [31:0] a, input logic [31:0] d);
        case (sel)
            1: begin
                bus1.stb = s; bus1.cyc = c; bus1.we = we;
                bus1.width = w; bus1.addr = a; bus1.data_write = d;
            end
            3: begin
                bus3.stb = s; bus3.cyc = c; bus3.we = we;
                bus3.width = w; bus3.addr = a; bus3.data_write = d;
            end
            default: begin
                bus4.stb = s; bus4.cyc = c; bus4.we = we;
                bus4.width = w; bus4.addr = a; bus4.data_write = d;
            end
        endcase
    endtask

    function automatic logic get_ack(input int sel);
        case (sel)
            1:       return bus1.ack;
            3:       return bus3.ack;
            default: return bus4.ack;
        endcase
    endfunction

    function automatic logic [31:0] get_rd(input int sel);
        case (sel)
            1:       return bus1.data_read;
            3:       return bus3.data_read;
            default: return bus4.data_read;
        endcase
    endfunction

    // One full transaction: raise the request, count cycles to ack, drop it, idle one cycle.
    task automatic access(input int sel, input logic we, input data_width_e w,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output logic ack_after);
        drive(sel, 1'b1, 1'b1, we, w, a, d);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!get_ack(sel) && lat < 20);
        if (!get_ack(sel)) begin
            checks++;
            $display("[TB] FAIL access_timeout: no ack after %0d cycles, required ack within 20", lat);
            lat = -1;
        end
        rd = get_rd(sel);
        drive(sel, 1'b0, 1'b0, 1'b0, eDW_W, 32'h0, 32'h0);
        @(negedge clk);
        ack_after = get_ack(sel);
    endtask

    task automatic test_reset();
        drive(1, 1'b0, 1'b0, 1'b0, eDW_W, 32'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 1'b0, eDW_W, 32'h0, 32'h0);
        drive(4, 1'b0, 1'b0, 1'b0, eDW_W, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 1; s <= 4; s++) begin
            if (s == 2) continue;
            checks++;
            if (get_ack(s) !== 1'b0)
                $display("[TB] FAIL reset_ack L%0d: got %b required 0", s, get_ack(s));
            else passes++;
            checks++;
            if (get_rd(s) !== 32'h0)
                $display("[TB] FAIL reset_data L%0d: got %h required 00000000", s, get_rd(s));
            else passes++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_write();
        logic [31:0] rd; int lat; logic aa;
        access(1, 1'b1, eDW_W, 32'h10, 32'hDEADBEEF, rd, lat, aa);
        checks++;
        if (lat !== 1) $display("[TB] FAIL l1_write_latency: got %0d required 1", lat);
        else passes++;
        checks++;
        if (aa !== 1'b0) $display("[TB] FAIL l1_ack_single: got %b required 0", aa);
        else passes++;
    endtask

    task automatic test_byte_half_reads();
        logic [31:0] rd; int lat; logic aa;
        logic [31:0] exp_b [4] = '{32'h000000EF, 32'h000000BE, 32'h000000AD, 32'h000000DE};
        for (int i = 0; i < 4; i++) begin
            access(1, 1'b0, eDW_B, 32'h10 + i, 32'h0, rd, lat, aa);
            checks++;
            if (rd !== exp_b[i])
                $display("[TB] FAIL byte_read_%0d: got %h required %h", i, rd, exp_b[i]);
            else passes++;
        end
        access(1, 1'b0, eDW_H, 32'h12, 32'h0, rd, lat, aa);
        checks++;
        if (rd !== 32'h0000DEAD) $display("[TB] FAIL half_read_hi: got %h required 0000DEAD", rd);
        else passes++;
        access(1, 1'b0, eDW_H, 32'h10, 32'h0, rd, lat, aa);
        checks++;
        if (rd !== 32'h0000BEEF) $display("[TB] FAIL half_read_lo: got %h required 0000BEEF", rd);
        else passes++;
    endtask

    task automatic test_lane_writes();
        logic [31:0] rd; int lat; logic aa;
        access(1, 1'b1, eDW_B, 32'h11, 32'hFFFFFF55, rd, lat, aa);
        access(1, 1'b0, eDW_W, 32'h10, 32'h0, rd, lat, aa);
        checks++;
        if (rd !== 32'hDEAD55EF) $display("[TB] FAIL byte_write: got %h required DEAD55EF", rd);
        else passes++;
        access(1, 1'b1, eDW_H, 32'h13, 32'hAAAA1234, rd, lat, aa);
        access(1, 1'b0, eDW_W, 32'h10, 32'h0, rd, lat, aa);
        checks++;
        if (rd !== 32'h123455EF) $display("[TB] FAIL half_write: got %h required 123455EF", rd);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat; int gap; logic ack_next; logic aa;
        drive(3, 1'b1, 1'b1, 1'b1, eDW_W, 32'h40, 32'h13572468);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus3.ack && lat < 20);
        checks++;
        if (lat !== 3) $display("[TB] FAIL l3_first_ack: got %0d cycles required 3", lat);
        else passes++;
        gap = 0;
        ack_next = 1'b1;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 1) ack_next = bus3.ack;
        end while (!bus3.ack && gap < 20);
        checks++;
        if (ack_next !== 1'b0) $display("[TB] FAIL l3_ack_single: got %b required 0", ack_next);
        else passes++;
        checks++;
        if (gap !== 4) $display("[TB] FAIL l3_ack_spacing: got %0d cycles required 4", gap);
        else passes++;
        drive(3, 1'b0, 1'b0, 1'b0, eDW_W, 32'h0, 32'h0);
        @(negedge clk);
        access(3, 1'b0, eDW_W, 32'h40, 32'h0, rd, lat, aa);
        checks++;
        if (rd !== 32'h13572468) $display("[TB] FAIL l3_readback: got %h required 13572468", rd);
        else passes++;
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lat; logic aa; logic seen;
        access(4, 1'b1, eDW_W, 32'h20, 32'h11223344, rd, lat, aa);
        checks++;
        if (lat !== 4) $display("[TB] FAIL l4_latency: got %0d required 4", lat);
        else passes++;
        drive(4, 1'b1, 1'b1, 1'b1, eDW_W, 32'h20, 32'hFFFFFFFF);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen |= bus4.ack;
        end
        drive(4, 1'b0, 1'b0, 1'b0, eDW_W, 32'h0, 32'h0);
        repeat (6) begin
            @(negedge clk);
            seen |= bus4.ack;
        end
        checks++;
        if (seen !== 1'b0) $display("[TB] FAIL abort_no_ack: got ack %b required 0", seen);
        else passes++;
        drive(4, 1'b1, 1'b0, 1'b1, eDW_W, 32'h20, 32'hFFFFFFFF);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= bus4.ack;
        end
        drive(4, 1'b0, 1'b0, 1'b0, eDW_W, 32'h0, 32'h0);
        checks++;
        if (seen !== 1'b0) $display("[TB] FAIL stb_without_cyc: got ack %b required 0", seen);
        else passes++;
        access(4, 1'b0, eDW_W, 32'h20, 32'h0, rd, lat, aa);
        checks++;
        if (rd !== 32'h11223344) $display("[TB] FAIL abort_mem_kept: got %h required 11223344", rd);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; logic aa; logic seen;
        drive(4, 1'b1, 1'b1, 1'b1, eDW_W, 32'h20, 32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drive(4, 1'b0, 1'b0, 1'b0, eDW_W, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (bus4.ack !== 1'b0) $display("[TB] FAIL midreset_ack: got %b required 0", bus4.ack);
        else passes++;
        checks++;
        if (bus4.data_read !== 32'h0)
            $display("[TB] FAIL midreset_data: got %h required 00000000", bus4.data_read);
        else passes++;
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= bus4.ack;
        end
        checks++;
        if (seen !== 1'b0) $display("[TB] FAIL midreset_no_ack: got ack %b required 0", seen);
        else passes++;
        access(4, 1'b0, eDW_W, 32'h20, 32'h0, rd, lat, aa);
        checks++;
        if (rd !== 32'h11223344) $display("[TB] FAIL midreset_mem_kept: got %h required 11223344", rd);
        else passes++;
        checks++;
        if (lat !== 4) $display("[TB] FAIL midreset_recover_latency: got %0d required 4", lat);
        else passes++;
    endtask

    task automatic test_alias();
        logic [31:0] rd; int lat; logic aa;
        access(1, 1'b1, eDW_W, 32'h1010, 32'hCAFEF00D, rd, lat, aa);
        access(1, 1'b0, eDW_W, 32'h10, 32'h0, rd, lat, aa);
        checks++;
        if (rd !== 32'hCAFEF00D) $display("[TB] FAIL alias_word: got %h required CAFEF00D", rd);
        else passes++;
        access(1, 1'b0, eDW_B, 32'h1013, 32'h0, rd, lat, aa);
        checks++;
        if (rd !== 32'h000000CA) $display("[TB] FAIL alias_byte: got %h required 000000CA", rd);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_byte_half_reads();
        test_lane_writes();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_alias();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
